// File: rtl/eoc_collector.sv
// eoc_collector: gathers end-of-computation words from NumChannels reporters.
// Optional watchdog compiled in with `define EOC_COLLECTOR_TIMEOUT_EN.
module eoc_collector #(
  parameter int NumChannels  = 4,
  parameter int CodeWidth    = 32,
  parameter int TimeoutWidth = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic [NumChannels-1:0]           chan_mask_i,
  input  logic [TimeoutWidth-1:0]          timeout_cycles_i,
  input  logic [NumChannels-1:0]           eoc_valid_i,
  input  logic [NumChannels*CodeWidth-1:0] eoc_code_i,
  output logic [NumChannels-1:0]           eoc_ready_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [CodeWidth-2:0]             exit_code_o,
  output logic [NumChannels-1:0]           fail_mask_o,
  output logic                             timeout_o
);

  localparam int RetWidth = CodeWidth - 1;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_e;

  state_e                 state_q;
  logic [NumChannels-1:0] mask_q;
  logic [NumChannels-1:0] done_q;
  logic [NumChannels-1:0] fail_q;
  logic [RetWidth-1:0]    exit_q;
  logic                   to_q;

  logic [NumChannels-1:0] acc;
  logic [NumChannels-1:0] fin;
  logic [NumChannels-1:0] nfail;
  logic [NumChannels-1:0] done_d;
  logic [NumChannels-1:0] fail_d;
  logic [RetWidth-1:0]    exit_d;
  logic                   hit;
  logic                   expire;

  assign busy_o      = (state_q == COLLECT);
  assign done_o      = (state_q == DONE);
  assign exit_code_o = exit_q;
  assign fail_mask_o = fail_q;
  assign timeout_o   = to_q;
  assign eoc_ready_o = busy_o ? (mask_q & ~done_q) : '0;

  always_comb begin
    acc    = eoc_valid_i & eoc_ready_o;
    fin    = '0;
    nfail  = '0;
    exit_d = exit_q;
    hit    = 1'b0;
    for (int i = 0; i < NumChannels; i++) begin
      fin[i]   = acc[i] & eoc_code_i[i*CodeWidth];
      nfail[i] = fin[i] & (|eoc_code_i[i*CodeWidth+1 +: RetWidth]);
    end
    // The first failing channel by index, old or new, owns exit_code.
    for (int i = 0; i < NumChannels; i++) begin
      if (!hit) begin
        if (nfail[i]) begin
          exit_d = eoc_code_i[i*CodeWidth+1 +: RetWidth];
          hit    = 1'b1;
        end else if (fail_q[i]) begin
          hit = 1'b1;
        end
      end
    end
    done_d = done_q | fin;
    fail_d = fail_q | nfail;
  end

`ifdef EOC_COLLECTOR_TIMEOUT_EN
  logic [TimeoutWidth-1:0] cnt_q;
  logic                    lim_q;

  assign expire = lim_q && (cnt_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      lim_q <= 1'b0;
    end else if (state_q != COLLECT) begin
      if (start_i) begin
        cnt_q <= timeout_cycles_i;
        lim_q <= |timeout_cycles_i;
      end
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - TimeoutWidth'(1);
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^timeout_cycles_i;
  assign expire         = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mask_q  <= '0;
      done_q  <= '0;
      fail_q  <= '0;
      exit_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            mask_q  <= chan_mask_i;
            done_q  <= '0;
            fail_q  <= '0;
            exit_q  <= '0;
            to_q    <= 1'b0;
            state_q <= (chan_mask_i == '0) ? DONE : COLLECT;
          end
        end
        COLLECT: begin
          done_q <= done_d;
          fail_q <= fail_d;
          exit_q <= exit_d;
          if (done_d == mask_q) begin
            state_q <= DONE;
          end else if (expire) begin
            state_q <= DONE;
            to_q    <= 1'b1;
            exit_q  <= '1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eoc_collector.sv
// tb_eoc_collector: scoreboard bench for eoc_collector.
// Watchdog cases follow EOC_COLLECTOR_TIMEOUT_EN.
module tb_eoc_collector;

  localparam int N  = 4;
  localparam int CW = 32;
  localparam int TW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [N-1:0]    mask;
  logic [TW-1:0]   tmo;
  logic [N-1:0]    valid;
  logic [N*CW-1:0] code;
  logic [N-1:0]    ready;
  logic            busy;
  logic            done;
  logic [CW-2:0]   exit_code;
  logic [N-1:0]    fail_mask;
  logic            timeout;

  eoc_collector #(
    .NumChannels (N),
    .CodeWidth   (CW),
    .TimeoutWidth(TW)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .chan_mask_i     (mask),
    .timeout_cycles_i(tmo),
    .eoc_valid_i     (valid),
    .eoc_code_i      (code),
    .eoc_ready_o     (ready),
    .busy_o          (busy),
    .done_o          (done),
    .exit_code_o     (exit_code),
    .fail_mask_o     (fail_mask),
    .timeout_o       (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [CW-2:0] ex;
    logic [N-1:0]  fl;
    logic          to;
  } res_t;

  res_t sb[$];

  logic [N-1:0]  m_mask;
  logic [N-1:0]  m_done;
  logic [N-1:0]  m_fail;
  logic [CW-2:0] m_exit;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic arm(input logic [N-1:0] m, input logic [TW-1:0] t);
    start  = 1'b1;
    mask   = m;
    tmo    = t;
    step(1);
    start  = 1'b0;
    m_mask = m;
    m_done = '0;
    m_fail = '0;
    m_exit = '0;
  endtask

  task automatic beat(input logic [N-1:0] v,
                      input logic [CW-1:0] c0, input logic [CW-1:0] c1,
                      input logic [CW-1:0] c2, input logic [CW-1:0] c3);
    logic [CW-1:0] cs [N];
    logic [N-1:0]  low;
    cs[0] = c0;
    cs[1] = c1;
    cs[2] = c2;
    cs[3] = c3;
    valid = v;
    code  = {c3, c2, c1, c0};
    for (int i = 0; i < N; i++) begin
      if (v[i] && m_mask[i] && !m_done[i] && cs[i][0]) begin
        m_done[i] = 1'b1;
        if (cs[i][CW-1:1] != '0) begin
          low = '0;
          for (int k = 0; k < i; k++) low[k] = 1'b1;
          if ((m_fail & low) == '0) m_exit = cs[i][CW-1:1];
          m_fail[i] = 1'b1;
        end
      end
    end
    step(1);
    valid = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) beat('0, '0, '0, '0, '0);
  endtask

  task automatic push_exp(input logic to);
    res_t r;
    r.ex = to ? '1 : m_exit;
    r.fl = m_fail;
    r.to = to;
    sb.push_back(r);
  endtask

  logic done_prev = 1'b0;

  always @(negedge clk) begin
    res_t r;
    if (done && !done_prev) begin
      chk("sb_nonempty", 64'(sb.size() > 0), 64'(1));
      if (sb.size() > 0) begin
        r = sb.pop_front();
        chk("sb_exit", 64'(exit_code), 64'(r.ex));
        chk("sb_fail", 64'(fail_mask), 64'(r.fl));
        chk("sb_to", 64'(timeout), 64'(r.to));
      end
    end
    done_prev = done;
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mask  = '0;
    tmo   = '0;
    valid = '0;
    code  = '0;
    step(2);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_ready", 64'(ready), 0);
    chk("rst_exit", 64'(exit_code), 0);
    chk("rst_fail", 64'(fail_mask), 0);
    chk("rst_to", 64'(timeout), 0);
    rst = 1'b0;
    step(1);

    // empty mask finishes at once
    m_mask = '0; m_done = '0; m_fail = '0; m_exit = '0;
    push_exp(1'b0);
    arm('0, '0);
    chk("zero_done", 64'(done), 1);
    chk("zero_busy", 64'(busy), 0);
    step(1);

    // all pass: reports in cycles 3, 5, 5, 9
    arm(4'hF, '0);
    chk("a_cleared", 64'(done), 0);
    chk("a_busy", 64'(busy), 1);
    chk("a_ready", 64'(ready), 64'hF);
    idle(2);
    beat(4'b0001, 1, 0, 0, 0);
    idle(1);
    beat(4'b0110, 0, 1, 1, 0);
    chk("a_ready_mid", 64'(ready), 64'h8);
    idle(3);
    chk("a_not_done", 64'(done), 0);
    beat(4'b1000, 0, 0, 0, 1);
    push_exp(1'b0);
    chk("a_done_t1", 64'(done), 1);
    chk("a_ready_done", 64'(ready), 0);
    step(3);
    chk("a_hold_done", 64'(done), 1);
    chk("a_hold_exit", 64'(exit_code), 0);

    // simultaneous failures on ch1/ch2
    arm(4'hF, '0);
    chk("b_cleared", 64'(done), 0);
    beat(4'b0110, 0, 32'h5, 32'h7, 0);
    beat(4'b1001, 1, 0, 0, 1);
    push_exp(1'b0);
    chk("b_fail", 64'(fail_mask), 64'h6);
    chk("b_exit", 64'(exit_code), 2);

    // lower index overrides a recorded higher failure
    arm(4'hF, '0);
    beat(4'b1000, 0, 0, 0, 32'hB);
    chk("c_exit_mid", 64'(exit_code), 5);
    beat(4'b0011, 1, 32'h7, 0, 0);
    beat(4'b0100, 0, 0, 1, 0);
    push_exp(1'b0);
    chk("c_exit", 64'(exit_code), 3);
    chk("c_fail", 64'(fail_mask), 64'hA);

    // channel outside the mask is never acknowledged
    arm(4'b0101, '0);
    for (int i = 0; i < 3; i++) begin
      beat(4'b0010, 0, 1, 0, 0);
      chk("d_rdy1", 64'(ready[1]), 0);
    end
    beat(4'b0011, 1, 1, 0, 0);
    chk("d_rdy1", 64'(ready[1]), 0);
    chk("d_not_done", 64'(done), 0);
    beat(4'b0110, 0, 1, 1, 0);
    push_exp(1'b0);
    chk("d_done", 64'(done), 1);

    // word without done flag is discarded; start in COLLECT ignored
    arm(4'b0001, '0);
    beat(4'b0001, 32'h4, 0, 0, 0);
    chk("e_busy", 64'(busy), 1);
    chk("e_ready", 64'(ready), 1);
    start = 1'b1;
    mask  = 4'hF;
    idle(1);
    start = 1'b0;
    chk("e_ign_busy", 64'(busy), 1);
    chk("e_ign_ready", 64'(ready), 1);
    beat(4'b0001, 1, 0, 0, 0);
    push_exp(1'b0);
    chk("e_done", 64'(done), 1);
    chk("e_exit", 64'(exit_code), 0);

    // reset mid-run with words pending
    arm(4'hF, '0);
    beat(4'b0001, 32'h3, 0, 0, 0);
    valid = 4'hF;
    code  = {4{32'h3}};
    rst   = 1'b1;
    step(1);
    rst   = 1'b0;
    chk("r_busy", 64'(busy), 0);
    chk("r_done", 64'(done), 0);
    chk("r_ready", 64'(ready), 0);
    chk("r_exit", 64'(exit_code), 0);
    chk("r_fail", 64'(fail_mask), 0);
    chk("r_to", 64'(timeout), 0);
    step(1);
    chk("r_idle_ready", 64'(ready), 0);
    valid = '0;
    arm(4'b0011, '0);
    beat(4'b0011, 1, 32'h9, 0, 0);
    push_exp(1'b0);
    chk("r_rerun_done", 64'(done), 1);
    chk("r_rerun_exit", 64'(exit_code), 4);

`ifdef EOC_COLLECTOR_TIMEOUT_EN
    // watchdog expiry: ch3 silent
    arm(4'hF, 20);
    beat(4'b0111, 1, 1, 1, 0);
    idle(19);
    chk("t_pre", 64'(done), 0);
    idle(1);
    push_exp(1'b1);
    chk("t_done", 64'(done), 1);
    chk("t_to", 64'(timeout), 1);
    chk("t_exit", 64'(exit_code), 64'h7FFF_FFFF);

    // completion exactly at expiry wins
    arm(4'hF, 20);
    beat(4'b0111, 1, 1, 1, 0);
    idle(19);
    chk("u_pre", 64'(done), 0);
    beat(4'b1000, 0, 0, 0, 1);
    push_exp(1'b0);
    chk("u_done", 64'(done), 1);
    chk("u_to", 64'(timeout), 0);
`else
    // no watchdog: waits indefinitely
    arm(4'hF, 3);
    beat(4'b0111, 1, 1, 1, 0);
    idle(10);
    chk("w_busy", 64'(busy), 1);
    chk("w_to", 64'(timeout), 0);
    beat(4'b1000, 0, 0, 0, 1);
    push_exp(1'b0);
    chk("w_done", 64'(done), 1);
    chk("w_to_end", 64'(timeout), 0);
`endif

    step(2);
    chk("sb_drained", 64'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eoc_collector.md
EOC_COLLECTOR -- requirements
Module: eoc_collector

Interface
REQ-001 SHALL have parameter NumChannels, default 4: number of end-of-computation (EOC) reporting channels, legal range 1..32.
REQ-002 SHALL have parameter CodeWidth, default 32: EOC word width; bit 0 is the done flag and bits [CodeWidth-1:1] are the return value.
REQ-003 SHALL have parameter TimeoutWidth, default 32: watchdog counter width.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start_i  input  1  arms a collection run.
REQ-007 SHALL have port chan_mask_i  input  NumChannels  channels expected to report; sampled when a run is armed.
REQ-008 SHALL have port timeout_cycles_i  input  TimeoutWidth  watchdog limit, where 0 means no limit; sampled when a run is armed.
REQ-009 SHALL have port eoc_valid_i  input  NumChannels  per-channel EOC word valid.
REQ-010 SHALL have port eoc_code_i  input  NumChannels*CodeWidth  per-channel EOC words; channel i occupies slice i.
REQ-011 SHALL have port eoc_ready_o  output  NumChannels  per-channel accept.
REQ-012 SHALL have port busy_o  output  1  high while state is COLLECT.
REQ-013 SHALL have port done_o  output  1  high while state is DONE.
REQ-014 SHALL have port exit_code_o  output  CodeWidth-1  aggregate return value.
REQ-015 SHALL have port fail_mask_o  output  NumChannels  channels that reported a non-zero return value.
REQ-016 SHALL have port timeout_o  output  1  the run ended by watchdog expiry.

Function
REQ-017 SHALL implement the FSM states IDLE, COLLECT and DONE.
REQ-018 In IDLE or DONE, start_i=1 SHALL, on the next cycle, latch chan_mask_i and timeout_cycles_i, clear the done mask, fail_mask_o, exit_code_o and timeout_o, and enter COLLECT.
REQ-019 start_i with a zero chan_mask_i SHALL go directly to DONE with exit_code_o=0.
REQ-020 start_i while in COLLECT SHALL be ignored.
REQ-021 In COLLECT, eoc_ready_o[i] SHALL equal latched_mask[i] & ~done_mask[i]; eoc_ready_o SHALL be 0 in IDLE and DONE.
REQ-022 A handshake is eoc_valid_i[i] & eoc_ready_o[i]; any number of channels SHALL be acceptable in the same cycle.
REQ-023 An accepted word with bit 0 = 0 SHALL be consumed and discarded without changing state.
REQ-024 An accepted word with bit 0 = 1 SHALL set done_mask[i], and SHALL set fail_mask_o[i] if its return value is non-zero.
REQ-025 exit_code_o SHALL equal the return value of the lowest-index failing channel; it SHALL be 0 if no channel failed.
REQ-026 On simultaneous failures, the lowest-index channel SHALL win, including over a higher-index failure that was already recorded.
REQ-027 When the registered done_mask equals latched_mask, the FSM SHALL enter DONE on the next edge: the final handshake in cycle t gives done_o=1 in cycle t+1.
REQ-028 done_o and all result outputs SHALL hold in DONE until start_i or rst_i.
REQ-029 eoc_valid_i on channels outside latched_mask SHALL be ignored and never acknowledged.

Reset
REQ-030 rst_i=1 at any clock edge SHALL force IDLE and clear all outputs and internal state to 0, including mid-run; pending words SHALL NOT be acknowledged.
REQ-031 rst_i SHALL take priority over start_i and over handshakes in the same cycle.

Configuration
REQ-032 Macro EOC_COLLECTOR_TIMEOUT_EN SHALL compile the watchdog in or out.
REQ-033 When EOC_COLLECTOR_TIMEOUT_EN is defined, a down-counter SHALL load timeout_cycles_i on arm and decrement every COLLECT cycle.
REQ-034 If the watchdog counter reaches 0 with channels outstanding, the FSM SHALL enter DONE next cycle with timeout_o=1 and exit_code_o all-ones.
REQ-035 If completion and watchdog expiry coincide in the same cycle, completion SHALL win and timeout_o SHALL stay 0.
REQ-036 When EOC_COLLECTOR_TIMEOUT_EN is undefined, no counter SHALL exist, timeout_cycles_i SHALL be ignored, timeout_o SHALL be tied to 0, and COLLECT SHALL wait indefinitely.

Verification
REQ-037 Bench: mask=4'b1111, channels report 0x1 in cycles 3, 5, 5 (two channels), 9 -> done_o rises in cycle 10, exit_code_o=0, fail_mask_o=0.
REQ-038 Bench: ch2 reports 0x7 and ch1 reports 0x5 in the same cycle, others report 0x1 -> fail_mask_o=4'b0110, exit_code_o=2.
REQ-039 Bench: mask=4'b0101, ch1 asserts valid -> eoc_ready_o[1]=0 throughout; done_o follows only ch0 and ch2.
REQ-040 Bench: ch0 sends 0x4 (done flag 0) then 0x1 -> the first word is discarded and only the second is recorded.
REQ-041 Bench with EOC_COLLECTOR_TIMEOUT_EN: timeout=20, ch3 silent -> timeout_o=1 and exit_code_o all-ones after 21 cycles; a second bench completing exactly at expiry -> timeout_o=0.
REQ-042 Bench: rst_i mid-COLLECT with valid asserted -> next cycle state is IDLE, all outputs 0, no ready asserted; a subsequent start_i runs cleanly.
